// File: rtl/mag_comp_seq.sv
// Sequential magnitude comparator: one 4-bit nibble compare per cycle, MSB nibble first.
// Optional feature macro MAG_COMP_SEQ_EARLY_EXIT_EN stops the walk at the first differing nibble.
module mag_comp_seq #(
    parameter  int NIBBLES = 4,
    localparam int SW      = $clog2(NIBBLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a_in,
    input  logic [4*NIBBLES-1:0]   b_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   L,
    output logic                   G,
    output logic                   E,
    output logic [SW-1:0]          steps
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [4*NIBBLES-1:0] a_reg;
    logic [4*NIBBLES-1:0] b_reg;
    logic [IW-1:0]        idx;
    logic                 diff_seen;
    logic                 sticky_gt;

    logic [3:0]           nib_a;
    logic [3:0]           nib_b;
    logic [1:0]           nib_res;
    logic                 nib_diff;
    logic                 next_diff;
    logic                 next_gt;
    logic                 run_last;

    // Returns {gt, lt}; the highest differing bit decides.
    function automatic logic [1:0] nib_cmp(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (r == 2'b00 && a[i] != b[i]) begin
                r = a[i] ? 2'b10 : 2'b01;
            end
        end
        return r;
    endfunction

    always_comb begin
        nib_a     = a_reg[4*idx +: 4];
        nib_b     = b_reg[4*idx +: 4];
        nib_res   = nib_cmp(nib_a, nib_b);
        nib_diff  = |nib_res;
        // The first differing nibble owns the result; later nibbles cannot change it.
        next_diff = diff_seen | nib_diff;
        next_gt   = diff_seen ? sticky_gt : nib_res[1];
`ifdef MAG_COMP_SEQ_EARLY_EXIT_EN
        run_last  = nib_diff || (idx == '0);
`else
        run_last  = (idx == '0);
`endif
    end

    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            diff_seen <= 1'b0;
            sticky_gt <= 1'b0;
            out_valid <= 1'b0;
            L         <= 1'b0;
            G         <= 1'b0;
            E         <= 1'b0;
            steps     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        idx       <= IW'(NIBBLES - 1);
                        diff_seen <= 1'b0;
                        sticky_gt <= 1'b0;
                        steps     <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    steps     <= steps + SW'(1);
                    diff_seen <= next_diff;
                    sticky_gt <= next_gt;
                    if (run_last) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        L         <= next_diff & ~next_gt;
                        G         <= next_diff &  next_gt;
                        E         <= ~next_diff;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        L         <= 1'b0;
                        G         <= 1'b0;
                        E         <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mag_comp_seq.md
# mag_comp_seq

Sequential magnitude comparator controller. It compares two wide unsigned operands by stepping one internal 4-bit nibble comparator from the most-significant nibble down to the least. It reports less / greater / equal flags through a valid/ready handshake. It sits between an operand producer and a result consumer, letting one narrow compare datapath serve operands of any width.

## Interface
- NIBBLES, default 4: operand width in nibbles, ≥1. Operands are 4*NIBBLES bits.
- SW = $clog2(NIBBLES+1), derived (localparam): width of `steps`.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a_in  in  4*NIBBLES  operand A, unsigned
- b_in  in  4*NIBBLES  operand B, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- L  out  1  A < B
- G  out  1  A > B
- E  out  1  A == B
- steps  out  SW  number of nibble compares performed for this result

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&&in_ready: latch a_in/b_in into internal registers, set idx=NIBBLES-1, clear the sticky result, clear the step count, go to RUN.
  - Operand inputs are ignored after acceptance.
- **RUN:** each cycle, compare nibble idx of A and B with an MSB-first bit-priority compare (bit 3 decides first, then bit 2, and so on), then increment the step count.
  - The sticky result records the first nibble that differs. Later nibbles never overwrite it.
  - If this nibble differs and early exit is enabled, go to DONE.
  - Else, if idx==0, go to DONE.
  - Else decrement idx and stay in RUN.
- **DONE:**
  - out_valid=1.
  - Exactly one of L/G/E is 1: L or G from the sticky result, or E=1 if no nibble differed.
  - L, G, E and steps stay stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, out_valid=0.
- **Invariants:** L+G+E==1 whenever out_valid=1. All three flags are 0 when out_valid=0.
- **NIBBLES=1:** RUN lasts exactly one cycle.

## Timing
- **Reset values:** state=IDLE, in_ready=1, out_valid=0, L=G=E=0, steps=0.
  - Assertion of rst_n mid-RUN or in DONE aborts immediately.
  - No result is emitted for an aborted operation.
- **Registered outputs:** out_valid, L, G, E, steps. in_ready is decoded combinationally from state.
- **Latency:** accept edge at cycle 0; first RUN compare in cycle 1; out_valid rises at cycle k+1, where k is the value of steps.
  - With early exit: k = (index from MSB of the first differing nibble) + 1, or NIBBLES if equal.
  - Without early exit: k = NIBBLES always.
- **Throughput:** one result per k+2 cycles minimum (accept, k compares, DONE handshake). in_ready is low in DONE even when out_ready=1, so the next accept happens no earlier than the cycle after DONE exits.
- **Simultaneous events:** in_valid asserted during RUN/DONE is not accepted, and the producer must hold it. out_ready asserted while out_valid=0 has no effect.

## Configuration
- **MAG_COMP_SEQ_EARLY_EXIT_EN:**
  - Defined: RUN terminates on the first differing nibble. This gives data-dependent latency and steps ≤ NIBBLES.
  - Undefined: every compare walks all NIBBLES nibbles. This gives constant latency NIBBLES+1 to out_valid and steps==NIBBLES. L/G/E results are identical in both builds.

## Test plan
- **Early-exit greater:** NIBBLES=4, A=0xA000, B=0x5000.
  - G=1, L=E=0.
  - With early exit: steps=1, out_valid at cycle 2.
  - Without early exit: steps=4, out_valid at cycle 5.
- **LSB-decided less:** A=0x1235, B=0x1236 → L=1, steps=4, out_valid at cycle 5 in both builds.
- **Equal:** A=B=0xBEEF → E=1, L=G=0, steps=4.
- **Backpressure:** A=0x0F00, B=0x0E00 with out_ready low for 5 cycles in DONE.
  - out_valid, G=1 and steps=2 (early exit) stay stable throughout.
  - in_ready=0 throughout, and a new in_valid is not accepted.
  - After out_ready=1, the block returns to IDLE and in_ready=1 the next cycle.
- **Reset mid-run:** A=0x0001, B=0x0002 without early exit; pulse rst_n low during the 2nd RUN cycle.
  - All outputs go to their reset values asynchronously.
  - No out_valid appears.
  - A following compare of A=0x0003, B=0x0003 returns E=1 correctly.
- **Back-to-back:** two operand pairs presented with in_valid held high.
  - The second pair is accepted exactly one cycle after the first DONE handshake.
  - Results are delivered in order.
